// File: rtl/fifo_burst_reader.sv
// Read-side burst consumer for async_fifo1: drains BURST_LEN words, checks them
// against an incrementing pattern from seed, and reports counts/first error/timeout.
module fifo_burst_reader #(
  parameter int DSIZE     = 8,
  parameter int BURST_LEN = 512,
  parameter int TIMEOUT   = 1024,
  parameter int CW        = $clog2(BURST_LEN+1)
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             start,
  input  logic [DSIZE-1:0] seed,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CW-1:0]    word_cnt,
  output logic [15:0]      err_cnt,
  output logic [CW-1:0]    first_err_idx
);

  localparam int SW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t           state, state_nxt;
  logic [DSIZE-1:0] expected;
  logic [SW-1:0]    stall_cnt;
  logic             last_rd, stall_hit, mismatch;

  always_comb begin
    state_nxt = state;
    rinc      = 1'b0;
    last_rd   = 1'b0;
    stall_hit = 1'b0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    mismatch  = (rdata != expected);
    case (state)
      IDLE: if (start) state_nxt = READ;
      READ: begin
        // rrst gates the strobe so a reset cycle never pops the FIFO
        rinc      = !rempty && !rrst;
        last_rd   = rinc && (word_cnt == CW'(BURST_LEN-1));
        stall_hit = rempty && (stall_cnt == SW'(TIMEOUT-1));
        if (last_rd || stall_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      expected      <= '0;
      stall_cnt     <= '0;
      word_cnt      <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      timeout       <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        expected      <= seed;
        stall_cnt     <= '0;
        word_cnt      <= '0;
        err_cnt       <= '0;
        first_err_idx <= '0;
        timeout       <= 1'b0;
      end
      if (state == READ) begin
        if (rinc) begin
          expected  <= expected + DSIZE'(1);
          word_cnt  <= word_cnt + CW'(1);
          stall_cnt <= '0;
          if (mismatch) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (err_cnt == 16'd0)    first_err_idx <= word_cnt;
          end
        end else if (rempty) begin
          stall_cnt <= stall_cnt + SW'(1);
        end
        if (stall_hit) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a queue-backed FIFO model feeds the DUT,
// each burst pushes its expected report, and a monitor checks it on the done pulse.
module tb_fifo_burst_reader;

  localparam int DSIZE = 8;
  localparam int BL    = 512;
  localparam int TO    = 1024;
  localparam int CW    = $clog2(BL+1);

  logic             rclk = 1'b0;
  logic             rrst, start, rempty;
  logic [DSIZE-1:0] seed, rdata;
  logic             rinc, busy, done, timeout;
  logic [CW-1:0]    word_cnt, first_err_idx;
  logic [15:0]      err_cnt;

  fifo_burst_reader #(.DSIZE(DSIZE), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .rclk(rclk), .rrst(rrst), .start(start), .seed(seed), .rempty(rempty),
    .rdata(rdata), .rinc(rinc), .busy(busy), .done(done), .timeout(timeout),
    .word_cnt(word_cnt), .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    int wc; int ec; int fe; int to; int rc; int rt;
  } exp_t;

  exp_t             sb[$];
  logic [DSIZE-1:0] fifo_q[$];
  int               stall_pts[$];
  int               stall_left = 0;
  int               rd_count   = 0;
  int               total = 0, passed = 0;
  int               rinc_cnt = 0, read_cyc = 0, done_cnt = 0, viol = 0;
  bit               chk_busy = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // FIFO model: rinc seen at negedge pops the head just after the next posedge
  initial begin
    bit take;
    rempty = 1'b1;
    rdata  = '0;
    forever begin
      @(negedge rclk);
      take = rinc;
      @(posedge rclk);
      #1;
      if (take && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        rd_count++;
      end
      if (stall_left == 0 && stall_pts.size() > 0 && rd_count == stall_pts[0]) begin
        void'(stall_pts.pop_front());
        stall_left = 50;
      end
      rempty = (stall_left > 0) || (fifo_q.size() == 0);
      rdata  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      if (stall_left > 0) stall_left--;
    end
  end

  // Monitor: protocol watch plus scoreboard pop on every done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge rclk);
      if (rinc && (rempty || rrst)) viol++;
      if (rinc) rinc_cnt++;
      if (busy && !done) read_cyc++;
      if (chk_busy) begin
        chk("busy_fall", int'(busy), 0);
        chk_busy = 0;
      end
      if (done) begin
        done_cnt++;
        chk_busy = 1;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("word_cnt",      int'(word_cnt),      e.wc);
          chk("err_cnt",       int'(err_cnt),       e.ec);
          chk("first_err_idx", int'(first_err_idx), e.fe);
          chk("timeout",       int'(timeout),       e.to);
          chk("rinc_pulses",   rinc_cnt,            e.rc);
          chk("read_cycles",   read_cyc,            e.rt);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge rclk); #2; end
  endtask

  task automatic load_pattern(input int n, input int first);
    fifo_q.delete();
    rd_count = 0;
    for (int i = 0; i < n; i++) fifo_q.push_back(DSIZE'(first + i));
  endtask

  task automatic pulse_start(input logic [DSIZE-1:0] s);
    rinc_cnt = 0;
    read_cyc = 0;
    seed  = s;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < limit && done_cnt == d0; i++) cyc(1);
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    cyc(3);
  endtask

  task automatic wait_idx(input int idx, input int limit);
    for (int i = 0; i < limit && rd_count != idx; i++) cyc(1);
    if (rd_count != idx) chk("idx_wait", rd_count, idx);
  endtask

  task automatic push_exp(input int wc, ec, fe, to, rc, rt);
    exp_t e;
    e.wc = wc; e.ec = ec; e.fe = fe; e.to = to; e.rc = rc; e.rt = rt;
    sb.push_back(e);
  endtask

  initial begin
    rrst  = 1'b1;
    start = 1'b1;
    seed  = '0;
    // Reset with start high and a non-empty FIFO
    load_pattern(BL, 0);
    cyc(3);
    chk("rst_rinc",     int'(rinc),          0);
    chk("rst_busy",     int'(busy),          0);
    chk("rst_done",     int'(done),          0);
    chk("rst_timeout",  int'(timeout),       0);
    chk("rst_word_cnt", int'(word_cnt),      0);
    chk("rst_err_cnt",  int'(err_cnt),       0);
    chk("rst_first",    int'(first_err_idx), 0);
    rrst  = 1'b0;
    start = 1'b0;
    cyc(1);

    // Clean burst with pattern wrap at index 256
    load_pattern(BL, 0);
    cyc(1);
    push_exp(512, 0, 0, 0, 512, 512);
    pulse_start(8'h00);
    wait_done(BL + 20);
    chk("hold_word_cnt", int'(word_cnt), 512);

    // Corruption at words 100 and 300
    load_pattern(BL, 0);
    fifo_q[100] = 8'hAA;
    fifo_q[300] = 8'hD3;
    cyc(1);
    push_exp(512, 2, 100, 0, 512, 512);
    pulse_start(8'h00);
    wait_done(BL + 20);

    // Two 50-cycle stalls
    load_pattern(BL, 0);
    stall_pts.push_back(200);
    stall_pts.push_back(400);
    cyc(1);
    push_exp(512, 0, 0, 0, 512, 612);
    pulse_start(8'h00);
    wait_done(BL + 150);

    // Timeout after 10 words
    load_pattern(10, 8'h10);
    cyc(1);
    push_exp(10, 0, 0, 1, 10, 10 + TO);
    pulse_start(8'h10);
    wait_done(TO + 100);

    // Control hazards: ignored start, then reset mid-burst
    load_pattern(BL, 0);
    cyc(1);
    pulse_start(8'h00);
    wait_idx(50, 200);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_idx(300, 400);
    chk("no_restart_wc", int'(word_cnt), 300);
    rrst = 1'b1;
    cyc(1);
    rrst = 1'b0;
    chk("mid_rst_busy",     int'(busy),     0);
    chk("mid_rst_word_cnt", int'(word_cnt), 0);
    chk("mid_rst_done",     int'(done),     0);
    chk("mid_rst_pops",     rd_count,       300);
    cyc(5);
    load_pattern(BL, 8'h20);
    cyc(1);
    push_exp(512, 0, 0, 0, 512, 512);
    pulse_start(8'h20);
    wait_done(BL + 20);

    chk("protocol_viol", viol, 0);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
